// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the single-RAM memory arbiter: MMIO addresses,
// response tag encodings and requester-select encodings.
package mem_arbiter_pkg;

  // MMIO window: stores here are accepted but never reach the RAM
  localparam logic [31:0] MMIO_PUTC = 32'h8000_0000;
  localparam logic [31:0] MMIO_GETC = 32'h8000_0004;
  localparam logic [31:0] MMIO_EXIT = 32'h8000_0008;

  // Response tags held in the in-order tag FIFO
  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  // Which requester owns the RAM port this cycle
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_FETCH = 2'd1,
    SEL_LOAD  = 2'd2,
    SEL_STORE = 2'd3
  } req_sel_e;

  function automatic logic is_mmio(input logic [31:0] addr);
    return (addr == MMIO_PUTC) || (addr == MMIO_GETC) || (addr == MMIO_EXIT);
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order 1-bit tag FIFO recording which requester each outstanding RAM
// read belongs to. Push and pop in the same cycle are allowed when full.
module arb_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  logic i_push_tag,
  input  logic i_pop,
  output logic o_head,
  output logic o_empty,
  output logic o_full
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [(1<<AW)-1:0] r_tags;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W-1:0]   w_count;
  logic               w_do_push;
  logic               w_do_pop;

  // Occupancy flags come from the wrap-extended pointers
  always_comb begin
    w_count   = r_wptr - r_rptr;
    o_empty   = (r_wptr == r_rptr);
    o_full    = (w_count == PTR_W'(DEPTH));
    o_head    = r_tags[AW'(r_rptr)];
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!o_full || w_do_pop);
  end

  // Pointer and storage update; asynchronous clear drops all tags
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_tags <= '0;
    end else begin
      if (w_do_push) begin
        r_tags[AW'(r_wptr)] <= i_push_tag;
        r_wptr              <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch, data load and data
// store. Store > load > fetch, except a fetch denied MAX_WAIT cycles in a row
// wins outright. Read responses are routed back in order through a tag FIFO;
// MMIO stores are accepted without touching the RAM.
//
// Handshake: a requester raises *_ready (request) and holds address/data;
// the arbiter answers with *_valid (accept) in the same cycle, combinationally.
// A request is consumed only in a cycle where both are high.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        imem_ready,
  input  logic [31:0] imem_addr,
  output logic        imem_valid,
  output logic        imem_rresp,
  output logic [31:0] imem_rdata,
  input  logic        dmem_rready,
  input  logic [31:0] dmem_raddr,
  output logic        dmem_rvalid,
  output logic        dmem_rresp,
  output logic [31:0] dmem_rdata,
  input  logic        dmem_wready,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_wvalid,
  output logic        mem_rready,
  output logic        mem_wready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rresp,
  input  logic [31:0] mem_rdata,
  output logic        arb_error
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] r_wait_cnt;
  logic          r_arb_error;
  req_sel_e      w_sel;
  logic          w_slot_ok;
  logic          w_starved;
  logic          w_store_mmio;
  logic          w_full;
  logic          w_empty;
  logic          w_head;
  logic          w_push;
  logic          w_pop;

  // Port selection, strobes and response routing
  always_comb begin
    w_slot_ok    = !w_full || mem_rresp;
    w_starved    = (r_wait_cnt == WW'(MAX_WAIT));
    w_store_mmio = resetb && dmem_wready && is_mmio(dmem_waddr);

    w_sel = SEL_NONE;
    if (!resetb)                                       w_sel = SEL_NONE;
    else if (imem_ready && w_slot_ok && w_starved)     w_sel = SEL_FETCH;
    else if (dmem_wready && !is_mmio(dmem_waddr))      w_sel = SEL_STORE;
    else if (dmem_rready && w_slot_ok)                 w_sel = SEL_LOAD;
    else if (imem_ready && w_slot_ok)                  w_sel = SEL_FETCH;

    imem_valid  = (w_sel == SEL_FETCH);
    dmem_rvalid = (w_sel == SEL_LOAD);
    dmem_wvalid = (w_sel == SEL_STORE) || w_store_mmio;
    mem_rready  = imem_valid || dmem_rvalid;
    mem_wready  = (w_sel == SEL_STORE);

    // Idle cycles keep the fetch address on the bus
    mem_addr = imem_addr;
    if (!resetb)          mem_addr = '0;
    else if (mem_wready)  mem_addr = dmem_waddr;
    else if (dmem_rvalid) mem_addr = dmem_raddr;

    mem_wdata = mem_wready ? dmem_wdata : '0;
    mem_wstrb = mem_wready ? dmem_wstrb : '0;

    w_push     = mem_rready;
    w_pop      = resetb && mem_rresp && !w_empty;
    imem_rresp = w_pop && (w_head == TAG_I);
    dmem_rresp = w_pop && (w_head == TAG_D);
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
    arb_error  = r_arb_error;
  end

  // Fetch starvation counter: counts consecutive denied fetch cycles
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_wait_cnt <= '0;
    end else if (!imem_ready || imem_valid) begin
      r_wait_cnt <= '0;
    end else if (!w_starved) begin
      r_wait_cnt <= r_wait_cnt + WW'(1);
    end
  end

  // Sticky error on a RAM response with no outstanding read
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_arb_error <= 1'b0;
    end else if (mem_rresp && w_empty) begin
      r_arb_error <= 1'b1;
    end
  end

  arb_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .i_rst_n   (resetb),
    .i_push    (w_push),
    .i_push_tag(dmem_rvalid ? TAG_D : TAG_I),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural model (priority rules,
// tag queue, expected-data queue) checked every cycle, a simple in-order RAM
// model with configurable latency, directed scenarios and a random phase.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TAG_DEPTH = 2;
  localparam int MAX_WAIT  = 4;
  localparam int W_NONE = 0, W_FETCH = 1, W_LOAD = 2, W_STORE = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_addr = '0;
  logic        imem_valid, imem_rresp;
  logic [31:0] imem_rdata;
  logic        dmem_rready = 1'b0;
  logic [31:0] dmem_raddr = '0;
  logic        dmem_rvalid, dmem_rresp;
  logic [31:0] dmem_rdata;
  logic        dmem_wready = 1'b0;
  logic [31:0] dmem_waddr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_wstrb = '0;
  logic        dmem_wvalid;
  logic        mem_rready, mem_wready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rresp = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        arb_error;

  always #5 clk = ~clk;

  mem_arbiter #(.TAG_DEPTH(TAG_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetb(resetb),
    .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rresp(imem_rresp), .imem_rdata(imem_rdata),
    .dmem_rready(dmem_rready), .dmem_raddr(dmem_raddr), .dmem_rvalid(dmem_rvalid),
    .dmem_rresp(dmem_rresp), .dmem_rdata(dmem_rdata),
    .dmem_wready(dmem_wready), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_wvalid(dmem_wvalid),
    .mem_rready(mem_rready), .mem_wready(mem_wready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rresp(mem_rresp), .mem_rdata(mem_rdata), .arb_error(arb_error)
  );

  // ---------------- scoreboard / model state ----------------
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];   // expected read data, oldest first
  bit          m_tag[$];   // 0 = fetch, 1 = load, oldest first
  int          m_wait = 0;
  bit          m_err = 0;
  // RAM model: pending responses in issue order
  int          ram_due[$];
  logic [31:0] ram_data[$];
  int          last_due = -1;
  int          ram_lat = 1;
  bit          spur_rresp = 0;
  // captured DUT outputs of the most recent step
  logic c_ivalid, c_dvalid, c_wvalid, c_mrd, c_mwr, c_irresp, c_drresp, c_err;
  logic [31:0] c_addr;
  logic [3:0]  c_wstrb;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: RAM drives its response, the model predicts every output,
  // the DUT is compared at the falling edge, then the model advances.
  task automatic step();
    int win;
    bit slot, mmio, e_irr, e_drr;
    logic [31:0] e_addr;
    if (ram_due.size() > 0 && ram_due[0] <= cyc) begin
      mem_rresp = 1'b1;
      mem_rdata = ram_data.pop_front();
      void'(ram_due.pop_front());
    end else begin
      mem_rresp = spur_rresp;
      mem_rdata = $urandom();
    end
    @(negedge clk);

    win = W_NONE; e_irr = 0; e_drr = 0; e_addr = '0;
    mmio = is_mmio(dmem_waddr);
    if (resetb) begin
      slot = (m_tag.size() < TAG_DEPTH) || mem_rresp;
      if (imem_ready && slot && m_wait == MAX_WAIT) win = W_FETCH;
      else if (dmem_wready && !mmio)                win = W_STORE;
      else if (dmem_rready && slot)                 win = W_LOAD;
      else if (imem_ready && slot)                  win = W_FETCH;
      e_addr = (win == W_STORE) ? dmem_waddr : (win == W_LOAD) ? dmem_raddr : imem_addr;
      if (mem_rresp && m_tag.size() > 0) begin
        e_irr = (m_tag[0] == 1'b0);
        e_drr = (m_tag[0] == 1'b1);
      end
    end

    check("imem_valid",  imem_valid,  win == W_FETCH);
    check("dmem_rvalid", dmem_rvalid, win == W_LOAD);
    check("dmem_wvalid", dmem_wvalid, resetb && dmem_wready && (mmio || win == W_STORE));
    check("mem_rready",  mem_rready,  win == W_FETCH || win == W_LOAD);
    check("mem_wready",  mem_wready,  win == W_STORE);
    check("mem_addr",    mem_addr,    e_addr);
    if (win == W_STORE || !resetb) begin
      check("mem_wdata", mem_wdata, resetb ? dmem_wdata : 32'h0);
      check("mem_wstrb", mem_wstrb, resetb ? dmem_wstrb : 4'h0);
    end
    check("imem_rresp",  imem_rresp,  e_irr);
    check("dmem_rresp",  dmem_rresp,  e_drr);
    check("arb_error",   arb_error,   resetb ? m_err : 1'b0);
    check("imem_rdata_pass", imem_rdata, mem_rdata);
    check("dmem_rdata_pass", dmem_rdata, mem_rdata);
    if ((e_irr || e_drr) && exp_q.size() > 0)
      check(e_irr ? "imem_rdata" : "dmem_rdata", e_irr ? imem_rdata : dmem_rdata, exp_q[0]);

    c_ivalid = imem_valid; c_dvalid = dmem_rvalid; c_wvalid = dmem_wvalid;
    c_mrd = mem_rready; c_mwr = mem_wready; c_irresp = imem_rresp; c_drresp = dmem_rresp;
    c_err = arb_error; c_addr = mem_addr; c_wstrb = mem_wstrb;

    if (!resetb) begin
      m_tag.delete(); exp_q.delete(); m_wait = 0; m_err = 0;
    end else begin
      if (mem_rresp) begin
        if (m_tag.size() > 0) begin
          void'(m_tag.pop_front());
          void'(exp_q.pop_front());
        end else begin
          m_err = 1;
        end
      end
      if (win == W_FETCH || win == W_LOAD) begin
        int due;
        m_tag.push_back(win == W_LOAD);
        exp_q.push_back(ram_word(e_addr));
        due = (cyc + ram_lat > last_due + 1) ? cyc + ram_lat : last_due + 1;
        last_due = due;
        ram_due.push_back(due);
        ram_data.push_back(ram_word(e_addr));
      end
      if (!imem_ready || win == W_FETCH) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    imem_ready = 0; dmem_rready = 0; dmem_wready = 0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (ram_due.size() > 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_done", ram_due.size(), 0);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] mmio_tab[3];
    mmio_tab[0] = MMIO_PUTC; mmio_tab[1] = MMIO_GETC; mmio_tab[2] = MMIO_EXIT;

    // reset state
    imem_addr = 32'h0000_0300;
    step(); step();
    check("rst mem_addr", c_addr, 32'h0);
    resetb = 1;
    step();
    check("idle addr=imem_addr", c_addr, 32'h0000_0300);
    check("idle no strobe", {c_mrd, c_mwr}, 2'b00);

    // 1: lone fetch, latency 1
    ram_lat = 1;
    imem_ready = 1; imem_addr = 32'h100;
    step();
    check("t1 imem_valid", c_ivalid, 1'b1);
    check("t1 mem_rready", c_mrd, 1'b1);
    check("t1 mem_addr", c_addr, 32'h100);
    idle();
    step();
    check("t1 imem_rresp", c_irresp, 1'b1);
    check("t1 dmem_rresp", c_drresp, 1'b0);
    check("t1 imem_rdata", imem_rdata, 32'hDEADBEEF);
    drain();

    // 2: store, load, fetch together
    imem_ready = 1; imem_addr = 32'h0;
    dmem_rready = 1; dmem_raddr = 32'h20000;
    dmem_wready = 1; dmem_waddr = 32'h20004; dmem_wdata = 32'h55; dmem_wstrb = 4'b0001;
    step();
    check("t2 c0 store", {c_mwr, c_wvalid, c_mrd}, 3'b110);
    check("t2 c0 wstrb", c_wstrb, 4'b0001);
    dmem_wready = 0;
    step();
    check("t2 c1 load", {c_dvalid, c_ivalid}, 2'b10);
    check("t2 c1 addr", c_addr, 32'h20000);
    dmem_rready = 0;
    step();
    check("t2 c2 fetch", c_ivalid, 1'b1);
    check("t2 c2 dmem_rresp", c_drresp, 1'b1);
    idle();
    step();
    check("t2 c3 imem_rresp", c_irresp, 1'b1);
    drain();

    // 3: continuous loads starve the fetch for MAX_WAIT cycles
    imem_ready = 1; imem_addr = 32'h40; dmem_rready = 1; dmem_raddr = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3 fetch denied", {c_ivalid, c_dvalid}, 2'b01);
    end
    step();
    check("t3 fetch promoted", {c_ivalid, c_dvalid}, 2'b10);
    step();
    check("t3 loads resume", {c_ivalid, c_dvalid}, 2'b01);
    drain();

    // 4: MMIO store does not consume the port
    dmem_wready = 1; dmem_waddr = MMIO_PUTC; dmem_wdata = 32'h41; dmem_wstrb = 4'hF;
    imem_ready = 1; imem_addr = 32'h40;
    step();
    check("t4 grants", {c_wvalid, c_ivalid, c_mwr, c_mrd}, 4'b1101);
    check("t4 mem_addr", c_addr, 32'h40);
    drain();

    // 5: tag FIFO full, latency 3
    ram_lat = 3;
    imem_ready = 1; imem_addr = 32'h80;
    step();
    imem_ready = 0; dmem_rready = 1; dmem_raddr = 32'h3000;
    step();
    dmem_rready = 0; imem_ready = 1; imem_addr = 32'h84;
    step();
    check("t5 withheld when full", c_ivalid, 1'b0);
    step();
    check("t5 grant with pop", {c_ivalid, c_irresp}, 2'b11);
    idle();
    step();
    check("t5 second resp D", {c_irresp, c_drresp}, 2'b01);
    step(); step();
    check("t5 third resp I", {c_irresp, c_drresp}, 2'b10);
    drain();

    // 6: spurious response, then reset with reads outstanding
    spur_rresp = 1;
    step();
    check("t6 no rresp on empty", {c_irresp, c_drresp}, 2'b00);
    spur_rresp = 0;
    step();
    check("t6 arb_error set", c_err, 1'b1);
    step();
    check("t6 arb_error sticky", c_err, 1'b1);
    imem_ready = 1; imem_addr = 32'h90;
    step();
    imem_ready = 0; dmem_rready = 1; dmem_raddr = 32'h3100;
    step();
    idle();
    resetb = 0;
    step();
    check("t6 err cleared in reset", c_err, 1'b0);
    resetb = 1;
    step();
    check("t6 stale resp not routed", {c_irresp, c_drresp}, 2'b00);
    step();
    check("t6 stale flags error", c_err, 1'b1);
    imem_ready = 1; imem_addr = 32'hA0;
    step();
    check("t6 grants resume", c_ivalid, 1'b1);
    drain();

    // random phase
    for (int i = 0; i < 400; i++) begin
      ram_lat     = $urandom_range(1, 3);
      imem_ready  = $urandom_range(0, 1);
      imem_addr   = $urandom() & 32'hFFFF_FFFC;
      dmem_rready = ($urandom_range(0, 2) == 0);
      dmem_raddr  = $urandom() & 32'hFFFF_FFFC;
      dmem_wready = ($urandom_range(0, 3) == 0);
      dmem_waddr  = ($urandom_range(0, 3) == 0) ? mmio_tab[$urandom_range(0, 2)]
                                                 : ($urandom() & 32'hFFFF_FFFC);
      dmem_wdata  = $urandom();
      dmem_wstrb  = 4'($urandom_range(1, 15));
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
